// File: rtl/seg_arb_pkg.sv
// Shared types and constants for the seven-segment display arbiter.
//   arb_state_e : arbiter FSM state (idle / serving a source)
//   TAG_W       : width of the source-index tag placed in val_out[31:28]
package seg_arb_pkg;

  typedef enum logic [0:0] {
    StIdle,
    StServe
  } arb_state_e;

  localparam int unsigned TAG_W = 4;

endpackage

// File: rtl/rr_pick.sv
// Combinational masked priority encoder for round-robin arbiters.
// Scans req_i starting at index ptr_i upward, wrapping modulo N, and returns the
// first set bit.
// Ports:
//   req_i  : per-requester request vector
//   ptr_i  : scan start index (must be < N)
//   gnt_o  : one-hot grant of the picked requester, all-zero if none
//   idx_o  : index of the picked requester, 0 if none
//   any_o  : high when at least one request is set
module rr_pick #(
  parameter int unsigned N    = 4,
  parameter int unsigned IdxW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]    req_i,
  input  logic [IdxW-1:0] ptr_i,
  output logic [N-1:0]    gnt_o,
  output logic [IdxW-1:0] idx_o,
  output logic            any_o
);

  int unsigned      cand;
  logic [IdxW-1:0]  cand_idx;

  always_comb begin
    gnt_o    = '0;
    idx_o    = '0;
    any_o    = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int unsigned off = 0; off < N; off++) begin
      cand     = (32'(ptr_i) + off) % N;
      cand_idx = IdxW'(cand);
      if (!any_o && req_i[cand_idx]) begin
        any_o           = 1'b1;
        idx_o           = cand_idx;
        gnt_o[cand_idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/seg_display_arbiter.sv
// Shares one 8-digit hex display between N_SRC debug sources. One source is granted
// at a time; its 32-bit value is registered to val_out (optionally tagged with the
// source index in the top nibble). Each grant is held for at least DWELL_CYCLES so the
// value is readable, then rotates round-robin among active requesters. The granted
// source may pin the display; a source dropping its request releases immediately.
// Ports:
//   clk_in     : system clock
//   rst_n_in   : asynchronous active-low reset
//   req_in     : per-source level request
//   pin_in     : per-source hold request, honoured only for the granted source
//   val_in     : packed source values, source i at [32*i+31:32*i]
//   grant_out  : one-hot grant, zero when idle
//   val_out    : value to the display controller
//   src_out    : granted source index, 0 when idle
//   active_out : high while any source is granted
//   switch_out : one-cycle pulse on every grant change (including to/from idle)
module seg_display_arbiter
  import seg_arb_pkg::*;
#(
  parameter int unsigned N_SRC        = 4,
  parameter int unsigned DWELL_CYCLES = 100_000_000,
  parameter logic [31:0] IDLE_VAL     = 32'h0000_0000,
  parameter bit          TAG_EN       = 1'b1
) (
  input  logic                       clk_in,
  input  logic                       rst_n_in,
  input  logic [N_SRC-1:0]           req_in,
  input  logic [N_SRC-1:0]           pin_in,
  input  logic [32*N_SRC-1:0]        val_in,
  output logic [N_SRC-1:0]           grant_out,
  output logic [31:0]                val_out,
  output logic [$clog2(N_SRC)-1:0]   src_out,
  output logic                       active_out,
  output logic                       switch_out
);

  localparam int unsigned IdxW = $clog2(N_SRC);
  // A 1-cycle dwell still needs a 1-bit counter that is permanently saturated.
  localparam int unsigned CntW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(DWELL_CYCLES - 1);

  arb_state_e       state_q, state_d;
  logic [N_SRC-1:0] gnt_q, gnt_d;
  logic [IdxW-1:0]  src_q, src_d;
  logic [IdxW-1:0]  rr_q, rr_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [31:0]      val_q, val_d;
  logic             active_q, active_d;
  logic             switch_q, switch_d;

  logic [31:0]      src_val [N_SRC];
  logic [N_SRC-1:0] pick_gnt;
  logic [IdxW-1:0]  pick_idx;
  logic             pick_any;
  logic             others;
  logic             take;
  logic [CntW-1:0]  cnt_inc;

  for (genvar i = 0; i < N_SRC; i++) begin : g_src_val
    assign src_val[i] = val_in[32*i +: 32];
  end

  rr_pick #(
    .N    (N_SRC),
    .IdxW (IdxW)
  ) u_pick (
    .req_i (req_in),
    .ptr_i (rr_q),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );

  // rr always points just past the last grant, so pick(rr) returns the current
  // holder only when nobody else is requesting.
  assign others  = |(req_in & ~gnt_q);
  assign cnt_inc = (cnt_q == CntMax) ? cnt_q : cnt_q + CntW'(1);

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    src_d    = src_q;
    rr_d     = rr_q;
    cnt_d    = cnt_q;
    switch_d = 1'b0;
    take     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (pick_any) take = 1'b1;
      end
      StServe: begin
        if (!req_in[src_q]) begin
          // Release is never held back by the dwell counter.
          if (pick_any) begin
            take = 1'b1;
          end else begin
            state_d  = StIdle;
            gnt_d    = '0;
            src_d    = '0;
            cnt_d    = '0;
            switch_d = 1'b1;
          end
        end else if (pin_in[src_q]) begin
          cnt_d = cnt_inc;
        end else if ((cnt_q == CntMax) && others) begin
          take = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: ;
    endcase

    if (take) begin
      state_d  = StServe;
      gnt_d    = pick_gnt;
      src_d    = pick_idx;
      cnt_d    = '0;
      switch_d = 1'b1;
      rr_d     = (pick_idx == IdxW'(N_SRC - 1)) ? '0 : pick_idx + IdxW'(1);
    end

    active_d = (state_d == StServe);

    // Value follows the grant being loaded at this edge, so it tracks the source live.
    val_d = IDLE_VAL;
    if (state_d == StServe) begin
      val_d = src_val[src_d];
      if (TAG_EN) val_d[31 -: TAG_W] = TAG_W'(src_d);
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q  <= StIdle;
      gnt_q    <= '0;
      src_q    <= '0;
      rr_q     <= '0;
      cnt_q    <= '0;
      val_q    <= IDLE_VAL;
      active_q <= 1'b0;
      switch_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      src_q    <= src_d;
      rr_q     <= rr_d;
      cnt_q    <= cnt_d;
      val_q    <= val_d;
      active_q <= active_d;
      switch_q <= switch_d;
    end
  end

  assign grant_out  = gnt_q;
  assign src_out    = src_q;
  assign val_out    = val_q;
  assign active_out = active_q;
  assign switch_out = switch_q;

endmodule

// File: tb/tb_seg_display_arbiter.sv
// Self-checking bench for seg_display_arbiter (N_SRC=4, DWELL_CYCLES=4, TAG_EN=1,
// IDLE_VAL=32'hDEAD_0000). Expected outputs come from a behavioural model that tracks
// the current holder, how long it has held, and the last granted index.
module tb_seg_display_arbiter;

  localparam int unsigned N    = 4;
  localparam int unsigned DW   = 4;
  localparam logic [31:0] IDLE = 32'hDEAD_0000;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [3:0]    req = '0;
  logic [3:0]    pin = '0;
  logic [31:0]   vals [4];
  logic [127:0]  val_in;
  logic [3:0]    grant_out;
  logic [31:0]   val_out;
  logic [1:0]    src_out;
  logic          active_out;
  logic          switch_out;

  int n_assert = 0;
  int n_fail   = 0;

  // Model state: holder (-1 idle), cycles held since grant, last granted index.
  int          m_g    = -1;
  int          m_held = 0;
  int          m_last = -1;
  logic        m_switch = 1'b0;
  logic [31:0] m_val = IDLE;

  always #5 clk = ~clk;

  assign val_in = {vals[3], vals[2], vals[1], vals[0]};

  seg_display_arbiter #(
    .N_SRC        (N),
    .DWELL_CYCLES (DW),
    .IDLE_VAL     (IDLE),
    .TAG_EN       (1'b1)
  ) dut (
    .clk_in     (clk),
    .rst_n_in   (rst_n),
    .req_in     (req),
    .pin_in     (pin),
    .val_in     (val_in),
    .grant_out  (grant_out),
    .val_out    (val_out),
    .src_out    (src_out),
    .active_out (active_out),
    .switch_out (switch_out)
  );

  // Round-robin: first requester after the last grant, skipping 'excl'.
  function automatic int pick(input logic [3:0] r, input int last, input int excl);
    for (int k = 0; k < N; k++) begin
      int i;
      i = (last + 1 + k) % N;
      if (i != excl && r[i]) return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_g = -1; m_held = 0; m_last = -1; m_switch = 1'b0; m_val = IDLE;
  endtask

  task automatic model_grant(input int p);
    m_g = p; m_last = p; m_held = 0; m_switch = 1'b1;
  endtask

  task automatic model_step();
    int p;
    m_switch = 1'b0;
    if (m_g < 0) begin
      p = pick(req, m_last, -1);
      if (p >= 0) model_grant(p);
    end else if (!req[m_g]) begin
      p = pick(req, m_last, m_g);
      if (p >= 0) model_grant(p);
      else begin
        m_g = -1; m_switch = 1'b1;
      end
    end else if (pin[m_g]) begin
      m_held++;
    end else begin
      p = pick(req, m_last, m_g);
      if (m_held >= DW - 1 && p >= 0) model_grant(p);
      else m_held++;
    end
    if (m_g < 0) m_val = IDLE;
    else m_val = {4'(m_g), vals[m_g][27:0]};
  endtask

  task automatic check(input string tag);
    logic [3:0] eg;
    logic [1:0] es;
    eg = (m_g < 0) ? 4'b0000 : 4'(1 << m_g);
    es = (m_g < 0) ? 2'd0 : 2'(m_g);
    n_assert++;
    assert (grant_out === eg) else begin
      n_fail++; $error("FAIL %s grant: got %b want %b", tag, grant_out, eg);
    end
    n_assert++;
    assert (src_out === es) else begin
      n_fail++; $error("FAIL %s src: got %0d want %0d", tag, src_out, es);
    end
    n_assert++;
    assert (val_out === m_val) else begin
      n_fail++; $error("FAIL %s val: got %h want %h", tag, val_out, m_val);
    end
    n_assert++;
    assert (active_out === (m_g >= 0)) else begin
      n_fail++; $error("FAIL %s active: got %b want %b", tag, active_out, m_g >= 0);
    end
    n_assert++;
    assert (switch_out === m_switch) else begin
      n_fail++; $error("FAIL %s switch: got %b want %b", tag, switch_out, m_switch);
    end
  endtask

  task automatic step(input string tag);
    model_step();
    @(posedge clk);
    #1;
    check(tag);
  endtask

  task automatic expect_grant(input string tag, input logic [3:0] want);
    n_assert++;
    assert (grant_out === want) else begin
      n_fail++; $error("FAIL %s: grant got %b want %b", tag, grant_out, want);
    end
  endtask

  task automatic pulse_reset();
    #2 rst_n = 1'b0;
    model_reset();
    #1 check("async_reset");
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    logic [3:0] seq [4];
    int         guard;
    seq[0] = 4'b0001; seq[1] = 4'b0010; seq[2] = 4'b1000; seq[3] = 4'b0001;
    for (int i = 0; i < 4; i++) vals[i] = 32'h1111_1111 * (i + 1);

    // Reset, then idle with no requests.
    model_reset();
    #12 check("in_reset");
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) step("idle");

    // Single requester: granted once, then held with no further pulses.
    vals[2] = 32'h0123_4567;
    req = 4'b0100;
    step("single_grant");
    n_assert++;
    assert (val_out === 32'h2123_4567) else begin
      n_fail++; $error("FAIL tagged_val: got %h want %h", val_out, 32'h2123_4567);
    end
    for (int i = 0; i < 12; i++) step("single_hold");

    // Round-robin from a fresh pointer: 0,1,3,0, four cycles each.
    pulse_reset();
    req = 4'b1011;
    for (int i = 0; i < 16; i++) begin
      step("rr_rotate");
      if (i % 4 == 0) expect_grant("rr_order", seq[i / 4]);
    end

    // Pin source 1 for 20 cycles, then release.
    req = 4'b0011;
    guard = 0;
    while (m_g != 1 && guard < 12) begin
      step("to_src1"); guard++;
    end
    n_assert++;
    assert (m_g == 1 && grant_out === 4'b0010) else begin
      n_fail++; $error("FAIL reach_src1: grant got %b want %b", grant_out, 4'b0010);
    end
    pin = 4'b0011;
    for (int i = 0; i < 20; i++) begin
      step("pinned"); expect_grant("pinned_src1", 4'b0010);
    end
    pin = 4'b0000;
    step("unpin");
    expect_grant("unpin_switch", 4'b0001);

    // Direct hand-off on release, then drop all to idle.
    req = 4'b1001;
    guard = 0;
    while (m_g != 3 && guard < 12) begin
      step("to_src3"); guard++;
    end
    req = 4'b0001;
    step("handoff");
    expect_grant("handoff_no_idle", 4'b0001);
    req = 4'b0000;
    step("drop_all");
    n_assert++;
    assert (val_out === IDLE && active_out === 1'b0) else begin
      n_fail++; $error("FAIL drop_idle: val %h active %b want %h 0", val_out, active_out, IDLE);
    end

    // Asynchronous reset mid-grant; arbitration restarts at index 0.
    req = 4'b0100;
    step("pre_reset"); step("pre_reset");
    pulse_reset();
    req = 4'b1111;
    step("restart");
    expect_grant("restart_rr0", 4'b0001);

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0) req = 4'($urandom);
      pin = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'b0000;
      if ($urandom_range(0, 2) == 0) vals[$urandom_range(0, 3)] = $urandom;
      step("random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
